// File: rtl/char_buffer_loader.sv
// -----------------------------------------------------------------------------
// char_buffer_loader
//
// Double-buffered 32-character line store for a text renderer. A writer
// streams bytes into the back buffer while the renderer reads the front
// buffer. A short line (wr_last) is padded with PAD_CHAR to the full width.
// The completed back buffer waits in PENDING until the next frame_start,
// at which point the two buffers exchange roles.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous, active-high reset
//   wr_valid     : wr_data holds a valid byte
//   wr_data[7:0] : character byte to store in the back buffer
//   wr_last      : accepted byte is the final byte of the line
//   wr_ready     : a byte can be accepted this cycle
//   frame_start  : one-cycle pulse at the start of vertical blanking
//   rd_addr[4:0] : character column requested by the renderer
//   rd_char[7:0] : front-buffer byte at rd_addr, one cycle later
//   rd_glyph[6:0]: rd_char - 33 for printable bytes, else 0
//   rd_blank     : rd_char lies outside 33..126
//   pending      : back buffer is complete and waiting for a swap
//   swap_count   : number of completed swaps, modulo 256
// -----------------------------------------------------------------------------
module char_buffer_loader #(
  parameter int         DEPTH    = 32,
  parameter logic [7:0] PAD_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  output logic       wr_ready,
  input  logic       frame_start,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] rd_glyph,
  output logic       rd_blank,
  output logic       pending,
  output logic [7:0] swap_count
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_PAD,
    S_PENDING
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wp_q, wp_d;
  logic          select_q, select_d;      // index of the front buffer
  logic [7:0]    swap_count_q, swap_count_d;
  logic          ready_q;                 // low until the first edge after reset

  logic [7:0]    mem_q [2][DEPTH];
  logic          wr_en;
  logic [7:0]    wr_byte;

  logic [7:0]    rd_char_q;
  logic [6:0]    rd_glyph_q;
  logic          rd_blank_q;

  logic [7:0]    front_byte;
  logic          front_blank;
  logic [6:0]    front_glyph;

  assign wr_ready   = ready_q && (state_q == S_FILL);
  assign pending    = (state_q == S_PENDING);
  assign swap_count = swap_count_q;
  assign rd_char    = rd_char_q;
  assign rd_glyph   = rd_glyph_q;
  assign rd_blank   = rd_blank_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_FILL;
      wp_q         <= '0;
      select_q     <= 1'b0;
      swap_count_q <= 8'd0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wp_q         <= wp_d;
      select_q     <= select_d;
      swap_count_q <= swap_count_d;
      ready_q      <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and write-port control
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    wp_d         = wp_q;
    select_d     = select_q;
    swap_count_d = swap_count_q;
    wr_en        = 1'b0;
    wr_byte      = wr_data;

    unique case (state_q)
      S_FILL: begin
        if (wr_valid && wr_ready) begin
          wr_en = 1'b1;
          wp_d  = wp_q + AW'(1);
          // A full line completes regardless of wr_last.
          if (wp_q == LAST) begin
            state_d = S_PENDING;
          end else if (wr_last) begin
            state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        wr_en   = 1'b1;
        wr_byte = PAD_CHAR;
        wp_d    = wp_q + AW'(1);
        if (wp_q == LAST) begin
          state_d = S_PENDING;
        end
      end
      S_PENDING: begin
        // frame_start only matters here; FILL and PAD ignore it.
        if (frame_start) begin
          select_d     = ~select_q;
          swap_count_d = swap_count_q + 8'd1;
          wp_d         = '0;
          state_d      = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Character buffers: writes go to the back buffer only
  // ---------------------------------------------------------------------------
  // NOTE: the buffers are flops rather than RAM because reset must load a
  // visible test pattern into every cell; a RAM macro could not do that.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[b][i] <= 8'h30 + 8'(i % 10);
        end
      end
    end else if (wr_en) begin
      mem_q[~select_q][wp_q] <= wr_byte;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read of the front buffer. On the swap edge select_q still holds
  // the old value, so that read returns the old front buffer.
  // ---------------------------------------------------------------------------
  assign front_byte  = mem_q[select_q][rd_addr];
  assign front_blank = (front_byte < 8'd33) || (front_byte > 8'd126);
  assign front_glyph = front_blank ? 7'd0 : 7'(front_byte - 8'd33);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_char_q  <= 8'h00;
      rd_glyph_q <= 7'd0;
      rd_blank_q <= 1'b1;
    end else begin
      rd_char_q  <= front_byte;
      rd_glyph_q <= front_glyph;
      rd_blank_q <= front_blank;
    end
  end

endmodule

// File: tb/tb_char_buffer_loader.sv
// -----------------------------------------------------------------------------
// tb_char_buffer_loader
//
// Directed bench for char_buffer_loader. Read-back expectations are kept in
// tables of {address, char, glyph, blank} records applied in a loop; the
// multi-cycle corners (padding length, swap timing, reset mid-fill, swap
// counter wrap) are hand-written sequences. Inputs change on the falling
// edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_char_buffer_loader;

  logic       clk         = 1'b0;
  logic       reset       = 1'b0;
  logic       wr_valid    = 1'b0;
  logic [7:0] wr_data     = 8'h00;
  logic       wr_last     = 1'b0;
  logic       frame_start = 1'b0;
  logic [4:0] rd_addr     = 5'd0;
  logic       wr_ready;
  logic [7:0] rd_char;
  logic [6:0] rd_glyph;
  logic       rd_blank;
  logic       pending;
  logic [7:0] swap_count;

  int n_pass  = 0;
  int n_total = 0;

  char_buffer_loader #(
    .DEPTH   (32),
    .PAD_CHAR(8'h20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .wr_ready   (wr_ready),
    .frame_start(frame_start),
    .rd_addr    (rd_addr),
    .rd_char    (rd_char),
    .rd_glyph   (rd_glyph),
    .rd_blank   (rd_blank),
    .pending    (pending),
    .swap_count (swap_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] ch;
    logic [6:0] glyph;
    logic       blank;
  } rd_vec_t;

  rd_vec_t reset_vecs[$];
  rd_vec_t abc_vecs[$];
  rd_vec_t full_vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_vecs(input string tag, input rd_vec_t vecs[$]);
    foreach (vecs[k]) begin
      rd_addr = vecs[k].addr;
      tick();
      check($sformatf("%s char[%0d]", tag, vecs[k].addr), rd_char, vecs[k].ch);
      check($sformatf("%s glyph[%0d]", tag, vecs[k].addr), rd_glyph, vecs[k].glyph);
      check($sformatf("%s blank[%0d]", tag, vecs[k].addr), rd_blank, vecs[k].blank);
    end
  endtask

  // Waits (bounded) for wr_ready, then presents one byte for one cycle.
  task automatic write_byte(input logic [7:0] data, input logic last, input logic fs);
    int n = 0;
    while (!wr_ready && n < 64) begin
      tick();
      n++;
    end
    if (!wr_ready) check("wr_ready wait timeout", wr_ready, 1);
    wr_valid    = 1'b1;
    wr_data     = data;
    wr_last     = last;
    frame_start = fs;
    tick();
    wr_valid    = 1'b0;
    wr_last     = 1'b0;
    frame_start = 1'b0;
  endtask

  // Waits (bounded) for pending; returns the number of cycles waited.
  task automatic wait_pending(output int cycles, output logic saw_ready);
    cycles    = 0;
    saw_ready = 1'b0;
    while (!pending && cycles < 100) begin
      if (wr_ready) saw_ready = 1'b1;
      tick();
      cycles++;
    end
    if (!pending) check("pending wait timeout", pending, 1);
  endtask

  task automatic pulse_swap();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    int   cycles;
    logic saw_ready;

    // Reset pattern: "0123456789" repeating, all printable.
    for (int i = 0; i < 32; i++) begin
      logic [7:0] c;
      c = 8'h30 + 8'(i % 10);
      reset_vecs.push_back('{addr: 5'(i), ch: c, glyph: 7'(c - 8'd33), blank: 1'b0});
    end
    abc_vecs.push_back('{addr: 5'd0,  ch: 8'h41, glyph: 7'd32, blank: 1'b0});
    abc_vecs.push_back('{addr: 5'd1,  ch: 8'h42, glyph: 7'd33, blank: 1'b0});
    abc_vecs.push_back('{addr: 5'd2,  ch: 8'h43, glyph: 7'd34, blank: 1'b0});
    abc_vecs.push_back('{addr: 5'd3,  ch: 8'h20, glyph: 7'd0,  blank: 1'b1});
    abc_vecs.push_back('{addr: 5'd17, ch: 8'h20, glyph: 7'd0,  blank: 1'b1});
    abc_vecs.push_back('{addr: 5'd31, ch: 8'h20, glyph: 7'd0,  blank: 1'b1});
    full_vecs.push_back('{addr: 5'd0,  ch: 8'h61, glyph: 7'd64, blank: 1'b0});
    full_vecs.push_back('{addr: 5'd29, ch: 8'h7e, glyph: 7'd93, blank: 1'b0});
    full_vecs.push_back('{addr: 5'd30, ch: 8'h7f, glyph: 7'd0,  blank: 1'b1});
    full_vecs.push_back('{addr: 5'd31, ch: 8'h80, glyph: 7'd0,  blank: 1'b1});

    // ---- Asynchronous reset, before any clock edge ----
    #1 reset = 1'b1;
    #1;
    check("reset wr_ready", wr_ready, 0);
    check("reset pending", pending, 0);
    check("reset swap_count", swap_count, 0);
    check("reset rd_char", rd_char, 8'h00);
    check("reset rd_glyph", rd_glyph, 0);
    check("reset rd_blank", rd_blank, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tick();
    check("wr_ready after release", wr_ready, 1);

    // ---- Sweep of the reset pattern ----
    run_vecs("reset sweep", reset_vecs);

    // ---- "ABC" short line, padded, then swapped ----
    write_byte(8'h41, 1'b0, 1'b0);
    write_byte(8'h42, 1'b0, 1'b0);
    write_byte(8'h43, 1'b1, 1'b0);
    wait_pending(cycles, saw_ready);
    check("pad cycles", cycles, 29);
    check("pad wr_ready low", saw_ready, 0);
    check("pending wr_ready", wr_ready, 0);
    rd_addr = 5'd0;
    tick();
    check("front before swap", rd_char, 8'h30);
    pulse_swap();
    check("swap_count after abc", swap_count, 1);
    check("pending cleared", pending, 0);
    check("fill after swap", wr_ready, 1);
    run_vecs("abc", abc_vecs);

    // ---- 32-byte line, frame_start coinciding with the last byte ----
    for (int i = 0; i < 32; i++) begin
      write_byte(8'h61 + 8'(i), 1'b0, (i == 31));
    end
    check("full pending", pending, 1);
    check("no swap on late pulse", swap_count, 1);
    rd_addr = 5'd5;
    tick();
    check("front held addr5", rd_char, 8'h20);
    // Read sampled on the swap edge returns the old front buffer.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("swap edge old data", rd_char, 8'h20);
    tick();
    check("after swap new data", rd_char, 8'h66);
    check("swap_count after full", swap_count, 2);
    run_vecs("full", full_vecs);

    // ---- Reset in the middle of a fill ----
    for (int i = 0; i < 10; i++) write_byte(8'h4a + 8'(i), 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("midfill reset wr_ready", wr_ready, 0);
    check("midfill reset swap_count", swap_count, 0);
    check("midfill reset rd_char", rd_char, 8'h00);
    check("midfill reset rd_blank", rd_blank, 1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("midfill pending", pending, 0);
    run_vecs("post reset", reset_vecs);

    // ---- 256 fill/swap rounds: counter wraps, select returns to 0 ----
    for (int k = 0; k < 256; k++) begin
      write_byte(8'(k), 1'b1, 1'b0);
      wait_pending(cycles, saw_ready);
      pulse_swap();
      if (k == 254) check("swap_count 255", swap_count, 8'd255);
    end
    check("swap_count wrap", swap_count, 8'd0);
    // Round 255 wrote buffer 0; an even toggle count makes it the front.
    rd_addr = 5'd0;
    tick();
    check("front after 256 swaps", rd_char, 8'hff);
    check("front blank 0xff", rd_blank, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
